// File: rtl/filter_loader.sv
// Serial 3x3x3 weight loader feeding four filter banks of the filter mux.
// Define FILTER_LOADER_CHECKSUM_EN to require a trailing checksum beat.
module filter_loader #(
  parameter int WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [1:0]                       bank_sel,
  input  logic [WIDTH-1:0]                 w_data,
  input  logic                             w_valid,
  output logic                             w_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [3:0]                       bank_valid,
  output logic [2:0][2:0][2:0][WIDTH-1:0]  filtro1,
  output logic [2:0][2:0][2:0][WIDTH-1:0]  filtro2,
  output logic [2:0][2:0][2:0][WIDTH-1:0]  filtro3,
  output logic [2:0][2:0][2:0][WIDTH-1:0]  filtro4
);

`ifdef FILTER_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

  state_t state, state_nx;

  logic [3:0][2:0][2:0][2:0][WIDTH-1:0] bank;
  logic [1:0] sel;
  logic [1:0] row, col, ch;
  logic       start_acc;
  logic       beat_acc;
  logic       last;
`ifdef FILTER_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum;
  logic             chk_acc;
`endif

  assign last = (row == 2'd2) && (col == 2'd2) && (ch == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    w_ready   = 1'b0;
    busy      = 1'b0;
    start_acc = 1'b0;
    beat_acc  = 1'b0;
`ifdef FILTER_LOADER_CHECKSUM_EN
    chk_acc   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = LOAD;
        end
      end
      LOAD: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_valid) begin
          beat_acc = 1'b1;
          if (last) begin
`ifdef FILTER_LOADER_CHECKSUM_EN
            state_nx = CHECK;
`else
            state_nx = IDLE;
`endif
          end
        end
      end
`ifdef FILTER_LOADER_CHECKSUM_EN
      CHECK: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_valid) begin
          chk_acc  = 1'b1;
          state_nx = IDLE;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank       <= '0;
      bank_valid <= '0;
      sel        <= '0;
      row        <= '0;
      col        <= '0;
      ch         <= '0;
      done       <= 1'b0;
`ifdef FILTER_LOADER_CHECKSUM_EN
      sum        <= '0;
      err        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef FILTER_LOADER_CHECKSUM_EN
      err  <= 1'b0;
`endif
      if (start_acc) begin
        sel                  <= bank_sel;
        bank_valid[bank_sel] <= 1'b0;
        row                  <= '0;
        col                  <= '0;
        ch                   <= '0;
`ifdef FILTER_LOADER_CHECKSUM_EN
        sum                  <= '0;
`endif
      end
      if (beat_acc) begin
        bank[sel][row][col][ch] <= w_data;
`ifdef FILTER_LOADER_CHECKSUM_EN
        sum <= sum + w_data;
`endif
        // channel fastest, then column, then row
        if (ch == 2'd2) begin
          ch <= '0;
          if (col == 2'd2) begin
            col <= '0;
            row <= row + 2'd1;
          end else begin
            col <= col + 2'd1;
          end
        end else begin
          ch <= ch + 2'd1;
        end
`ifndef FILTER_LOADER_CHECKSUM_EN
        if (last) begin
          bank_valid[sel] <= 1'b1;
          done            <= 1'b1;
        end
`endif
      end
`ifdef FILTER_LOADER_CHECKSUM_EN
      if (chk_acc) begin
        done <= 1'b1;
        if (w_data == sum) bank_valid[sel] <= 1'b1;
        else               err             <= 1'b1;
      end
`endif
    end
  end

`ifndef FILTER_LOADER_CHECKSUM_EN
  assign err = 1'b0;
`endif

  assign filtro1 = bank[0];
  assign filtro2 = bank[1];
  assign filtro3 = bank[2];
  assign filtro4 = bank[3];

endmodule

// File: tb/tb_filter_loader.sv
// Directed bench for filter_loader: bank loads, gaps, ignored start,
// reload, mid-load reset and (when enabled) checksum handling.
module tb_filter_loader;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] bank_sel;
  logic [W-1:0] w_data;
  logic w_valid;
  logic w_ready;
  logic busy;
  logic done;
  logic err;
  logic [3:0] bank_valid;
  logic [2:0][2:0][2:0][W-1:0] filtro1, filtro2, filtro3, filtro4;

  filter_loader #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .busy(busy), .done(done), .err(err), .bank_valid(bank_valid),
    .filtro1(filtro1), .filtro2(filtro2),
    .filtro3(filtro3), .filtro4(filtro4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [W-1:0] wts [27];
  logic early_done;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [215:0] exp_bank();
    logic [215:0] v;
    v = '0;
    for (int k = 0; k < 27; k++) v[k*8 +: 8] = wts[k];
    return v;
  endfunction

  function automatic logic [W-1:0] wsum();
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < 27; k++) s = s + wts[k];
    return s;
  endfunction

  task automatic do_start(input logic [1:0] b);
    start = 1'b1;
    bank_sel = b;
    tick();
    start = 1'b0;
    bank_sel = 2'd0;
  endtask

  // nb beats; gaps inserts one idle cycle between beats;
  // stray_k raises start for bank3 alongside that beat
  task automatic beats(input int nb, input bit gaps, input int stray_k);
    early_done = 1'b0;
    for (int k = 0; k < nb; k++) begin
      if (gaps && k > 0) begin
        w_valid = 1'b0;
        tick();
        early_done |= done;
      end
      w_valid = 1'b1;
      w_data = wts[k];
      if (k == stray_k) begin
        start = 1'b1;
        bank_sel = 2'd3;
      end
      tick();
      start = 1'b0;
      bank_sel = 2'd0;
      if (k < 26) early_done |= done;
    end
    w_valid = 1'b0;
    w_data = '0;
  endtask

  task automatic finish_load(input logic [W-1:0] adj);
`ifdef FILTER_LOADER_CHECKSUM_EN
    early_done |= done;
    w_valid = 1'b1;
    w_data = wsum() + adj;
    tick();
    w_valid = 1'b0;
    w_data = '0;
`endif
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bank_sel = 2'd0;
    w_data = '0;
    w_valid = 1'b0;
    tick();
    chk("rst_flags", {busy, w_ready, done, err}, 4'b0000);
    chk("rst_bv", bank_valid, 4'b0000);
    chk("rst_banks", {filtro1, filtro2, filtro3, filtro4}, '0);
    rst = 1'b0;
    tick();

    // bank2, values 1..27 at full rate
    for (int k = 0; k < 27; k++) wts[k] = W'(k + 1);
    chk("idle_no_ready", w_ready, 1'b0);
    do_start(2'd2);
    chk("start_busy", {busy, w_ready}, 2'b11);
    beats(27, 1'b0, -1);
    finish_load('0);
    chk("b2_done", {done, err, busy, w_ready}, 4'b1000);
    chk("b2_no_early", early_done, 1'b0);
    chk("b2_bv", bank_valid, 4'b0100);
    chk("b2_data", filtro3, exp_bank());
    chk("b2_r1c2ch0", filtro3[1][2][0], 8'd16);
    chk("b2_others", {filtro1, filtro2, filtro4}, '0);
    tick();
    chk("b2_done_pulse", done, 1'b0);

    // bank0 with w_valid toggling
    for (int k = 0; k < 27; k++) wts[k] = W'(7 * k + 3);
    do_start(2'd0);
    beats(27, 1'b1, -1);
    finish_load('0);
    chk("b0_done", {done, err}, 2'b10);
    chk("b0_no_early", early_done, 1'b0);
    chk("b0_bv", bank_valid, 4'b0101);
    chk("b0_data", filtro1, exp_bank());
    tick();

    // bank1 with a stray start for bank3 mid-load
    for (int k = 0; k < 27; k++) wts[k] = W'(200 - 5 * k);
    do_start(2'd1);
    beats(27, 1'b0, 5);
    finish_load('0);
    chk("b1_done", {done, err}, 2'b10);
    chk("b1_bv", bank_valid, 4'b0111);
    chk("b1_data", filtro2, exp_bank());
    chk("b1_bank3", filtro4, '0);

    // back-to-back reload of bank2 while done is high
    for (int k = 0; k < 27; k++) wts[k] = W'(k * k);
    do_start(2'd2);
    chk("rl_busy", busy, 1'b1);
    chk("rl_bv_drop", bank_valid, 4'b0011);
    beats(27, 1'b0, -1);
    finish_load('0);
    chk("rl_done", done, 1'b1);
    chk("rl_bv_back", bank_valid, 4'b0111);
    chk("rl_data", filtro3, exp_bank());
    tick();

`ifdef FILTER_LOADER_CHECKSUM_EN
    for (int k = 0; k < 27; k++) wts[k] = 8'h0A;
    chk("ck_sum_model", wsum(), 8'h0E);
    do_start(2'd3);
    beats(27, 1'b0, -1);
    chk("ck_wait", {done, busy, w_ready}, 3'b011);
    finish_load(8'h00);
    chk("ck_ok", {done, err}, 2'b10);
    chk("ck_ok_bv", bank_valid, 4'b1111);
    tick();
    do_start(2'd3);
    beats(27, 1'b0, -1);
    finish_load(8'h01);
    chk("ck_bad", {done, err}, 2'b11);
    chk("ck_bad_bv", bank_valid, 4'b0111);
    chk("ck_bad_data", filtro4, exp_bank());
    tick();
    chk("ck_err_pulse", {done, err}, 2'b00);
`endif

    // reset after beat 10 of a bank0 load
    for (int k = 0; k < 27; k++) wts[k] = W'(k + 40);
    do_start(2'd0);
    beats(10, 1'b0, -1);
    w_valid = 1'b1;
    w_data = 8'hFF;
    rst = 1'b1;
    #1;
    chk("mrst_flags", {busy, w_ready, done, err}, 4'b0000);
    chk("mrst_bv", bank_valid, 4'b0000);
    chk("mrst_banks", {filtro1, filtro2, filtro3, filtro4}, '0);
    tick();
    chk("mrst_hold", filtro1, '0);
    w_valid = 1'b0;
    w_data = '0;
    rst = 1'b0;
    tick();
    chk("mrst_idle", {busy, w_ready}, 2'b00);
    do_start(2'd0);
    beats(27, 1'b0, -1);
    finish_load('0);
    chk("fresh_done", done, 1'b1);
    chk("fresh_bv", bank_valid, 4'b0001);
    chk("fresh_data", filtro1, exp_bank());
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
